sipo_rx_controller: RTL
=======================

// Module: sipo_rx_controller
// PURPOSE
//  Sequencer for a 4-bit-style serial-in/parallel-out shift register. Frames serial bits
//  after a Start pulse, drives the shift enable, counts bits and hands each assembled
//  word to a consumer through a valid/ready holding register. Sits between a serial bit
//  source (switch/button or external serial line) and parallel logic such as LEDs or a 7-seg.
// PARAMETERS
//  WIDTH    4                   bits per word (>=2)
//  CNT_W    $clog2(WIDTH+1)     bit-counter width (derived; do not override)
// PORTS
//  Clk          in   1       system clock, all state on rising edge
//  Resetn       in   1       asynchronous, active-low reset
//  Start        in   1       begin a frame (sampled only in IDLE)
//  BitValid     in   1       ShiftIn carries a valid bit this cycle
//  ShiftIn      in   1       serial data bit
//  ShiftEn      out  1       shift strobe (combinational: SHIFT state & BitValid)
//  Busy         out  1       1 when not IDLE
//  BitCount     out  CNT_W   bits shifted in the current frame
//  ParallelOut  out  WIDTH   live shift-register contents
//  DataOut      out  WIDTH   holding register (completed word)
//  DataValid    out  1       DataOut holds an unconsumed word
//  DataReady    in   1       consumer accepts DataOut when DataValid & DataReady
//  Overrun      out  1       sticky: a completed word was dropped
//  ClearErr     in   1       synchronous clear of sticky error flags
// BEHAVIOUR
//  Reset (async, Resetn=0): state IDLE; shift reg, BitCount, DataOut = 0; DataValid,
//   Overrun, Busy, ShiftEn = 0. Reset mid-frame discards the partial word immediately.
//  Shift: on edge with ShiftEn=1, sreg <= {sreg[WIDTH-2:0], ShiftIn}; first bit ends in MSB.
//  FSM: IDLE --Start--> SHIFT. SHIFT: each BitValid shifts + BitCount++; BitValid=0 holds.
//   Edge capturing bit WIDTH: word {sreg[WIDTH-2:0],ShiftIn} goes to holding path,
//   BitCount <= 0, state -> IDLE (or PARITY when PARITY_CHECK_EN). Start ignored outside IDLE.
//  Latency: DataValid rises on the same edge that shifts in the final (or parity) bit.
//  Holding register: DataValid clears on DataValid&DataReady edge.
//   Load when DataValid=0, or when same-edge accept (DataValid&DataReady): load wins,
//   DataValid stays 1, no overrun. DataValid=1 & DataReady=0 at load: new word dropped,
//   DataOut unchanged, Overrun <= 1.
//  ClearErr clears sticky flags; a same-cycle new error wins (flag stays 1).
//  Start and final-bit on same edge in IDLE->n/a; back-to-back frames: Start may be
//   asserted the cycle after return to IDLE (one idle cycle minimum between frames).
// CONFIGURATION
//  PARITY_CHECK_EN defined: extra state PARITY after WIDTH data bits; next BitValid bit is
//   even-parity bit (ShiftIn must equal ^word). ShiftEn stays 0 in PARITY. Word is loaded
//   only on correct parity; mismatch drops word and sets sticky output ParityErr (1 bit,
//   reset 0, cleared by ClearErr). Frame = WIDTH+1 bits.
//  Not defined: no PARITY state, no ParityErr port; word loads after WIDTH-th bit.
// TESTING
//  1 Reset, Start, bits 1,0,1,1 with BitValid every cycle, DataReady=1 -> DataOut=4'b1011,
//    DataValid 1 for one cycle, ShiftEn high exactly 4 cycles, Busy low after.
//  2 Bits 1,1,0,0 with BitValid gaps (1,0,0,1,1,0,1) -> BitCount holds in gaps, DataOut=4'b1100.
//  3 DataReady=0: frame 4'b0110 then frame 4'b1001 -> DataOut stays 0110, Overrun=1;
//    ClearErr -> Overrun=0; DataReady=1 -> DataValid=0.
//  4 DataValid=1, DataReady=1 on edge completing 4'b0011 -> DataOut=0011, DataValid=1, Overrun=0.
//  5 Resetn low after 2 bits of a frame -> all outputs 0 async; next Start+1,1,1,1 -> 4'b1111.
//  6 PARITY_CHECK_EN: 1,0,1,0 + parity 0 -> DataOut=1010; 1,0,1,0 + parity 1 -> no load, ParityErr=1.

Source files
------------

// File: rtl/sipo_rx_controller.sv
// sipo_rx_controller: frames serial bits after a Start pulse, drives the
// shift strobe, counts bits and hands each completed word to a consumer
// through a valid/ready holding register with sticky overrun reporting.
// Optional feature macro: PARITY_CHECK_EN (adds an even-parity bit per frame
// and the sticky ParityErr output).

module sipo_rx_controller #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Start,
    input  logic             BitValid,
    input  logic             ShiftIn,
    output logic             ShiftEn,
    output logic             Busy,
    output logic [CNT_W-1:0] BitCount,
    output logic [WIDTH-1:0] ParallelOut,
    output logic [WIDTH-1:0] DataOut,
    output logic             DataValid,
    input  logic             DataReady,
    output logic             Overrun,
    input  logic             ClearErr
`ifdef PARITY_CHECK_EN
    ,
    output logic             ParityErr
`endif
);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT
    } state_t;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   sreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic               shift_en;
    logic               last_bit;
    logic               load_req;
    logic [WIDTH-1:0]   load_word;
    logic               word_drop;
    logic [WIDTH-1:0]   data_out;
    logic               data_valid;
    logic               overrun;
`ifdef PARITY_CHECK_EN
    logic               parity_fail;
    logic               parity_err;
`endif

    assign last_bit  = (bit_cnt == LAST_CNT);
    assign word_drop = load_req & data_valid & ~DataReady;

    // State register
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, shift strobe and word hand-off request
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        load_req   = 1'b0;
        load_word  = {sreg[WIDTH-2:0], ShiftIn};
`ifdef PARITY_CHECK_EN
        parity_fail = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (BitValid) begin
                    shift_en = 1'b1;
                    if (last_bit) begin
`ifdef PARITY_CHECK_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_IDLE;
                        load_req   = 1'b1;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            ST_PARITY: begin
                // The data word is already fully shifted into sreg here.
                load_word = sreg;
                if (BitValid) begin
                    state_next = ST_IDLE;
                    if (ShiftIn == ^sreg) begin
                        load_req = 1'b1;
                    end else begin
                        parity_fail = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Shift register: first received bit ends up in the MSB
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            sreg <= '0;
        end else if (shift_en) begin
            sreg <= {sreg[WIDTH-2:0], ShiftIn};
        end
    end

    // Bit counter, wraps to zero on the edge that captures the last data bit
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            if (last_bit) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Holding register: a load wins over a same-edge accept; a load into an
    // unconsumed word is dropped
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (load_req && (!data_valid || DataReady)) begin
            data_out   <= load_word;
            data_valid <= 1'b1;
        end else if (data_valid && DataReady) begin
            data_valid <= 1'b0;
        end
    end

    // Sticky overrun flag; a new drop beats a same-cycle clear
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            overrun <= 1'b0;
        end else if (word_drop) begin
            overrun <= 1'b1;
        end else if (ClearErr) begin
            overrun <= 1'b0;
        end
    end

`ifdef PARITY_CHECK_EN
    // Sticky parity error flag; a new mismatch beats a same-cycle clear
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            parity_err <= 1'b0;
        end else if (parity_fail) begin
            parity_err <= 1'b1;
        end else if (ClearErr) begin
            parity_err <= 1'b0;
        end
    end

    assign ParityErr = parity_err;
`endif

    assign ShiftEn     = shift_en;
    assign Busy        = (state != ST_IDLE);
    assign BitCount    = bit_cnt;
    assign ParallelOut = sreg;
    assign DataOut     = data_out;
    assign DataValid   = data_valid;
    assign Overrun     = overrun;

endmodule
